// File: rtl/riscv_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_muldiv_pkg
// Shared definitions for the EX-stage RV32M multiply/divide unit:
//   - default operand width (MD_XLEN)
//   - funct3 encodings of the M-extension operations
//   - controller state enum
//   - RISC-V divide corner-case constants (MIN_INT, ALL_ONES)
// Optional feature macro used by the unit: MULDIV_ZERO_SKIP_EN
// -----------------------------------------------------------------------------
package riscv_muldiv_pkg;

  localparam int unsigned MD_XLEN = 32;

  // funct3 encodings of the M-extension operations
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  // Corner-case constants at the default width
  localparam logic [MD_XLEN-1:0] MIN_INT  = {1'b1, {(MD_XLEN-1){1'b0}}};
  localparam logic [MD_XLEN-1:0] ALL_ONES = {MD_XLEN{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_operand_prep.sv
// -----------------------------------------------------------------------------
// muldiv_operand_prep
// Combinational operand conditioning for the iterative multiply/divide unit.
// Decides per-op signedness, converts both operands to magnitudes, produces the
// sign to apply to the final result and detects the single-cycle cases.
//
// Ports:
//   i_op             funct3 of the M-extension operation
//   i_rs1 / i_rs2    forwarded source operands
//   o_absRs1/2       operand magnitudes (unsigned)
//   o_negResult      final result must be negated (product / quotient sign,
//                    or dividend sign for REM)
//   o_special        operation completes without iterating
//   o_specialResult  result to use when o_special is set
//
// Optional feature macro: MULDIV_ZERO_SKIP_EN
//   When defined, a multiply with a zero operand or a divide of zero by a
//   nonzero divisor is also reported as a single-cycle case with result 0.
// -----------------------------------------------------------------------------
module muldiv_operand_prep
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic [XLEN-1:0] o_absRs1,
  output logic [XLEN-1:0] o_absRs2,
  output logic            o_negResult,
  output logic            o_special,
  output logic [XLEN-1:0] o_specialResult
);

  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES_VAL = {XLEN{1'b1}};

  logic w_isDiv;
  logic w_isRem;
  logic w_rs1Signed;
  logic w_rs2Signed;
  logic w_rs1Neg;
  logic w_rs2Neg;
  logic w_divZero;
  logic w_overflow;
  logic w_zeroSkip;

  assign w_isDiv = i_op[2];
  assign w_isRem = i_op[2] & i_op[1];

  // MUL is treated as unsigned: its low half is identical either way
  assign w_rs1Signed = (i_op == OP_MULH) | (i_op == OP_MULHSU) |
                       (i_op == OP_DIV)  | (i_op == OP_REM);
  assign w_rs2Signed = (i_op == OP_MULH) | (i_op == OP_DIV) | (i_op == OP_REM);

  assign w_rs1Neg = w_rs1Signed & i_rs1[XLEN-1];
  assign w_rs2Neg = w_rs2Signed & i_rs2[XLEN-1];

  // Negating MIN_VAL yields MIN_VAL, which is the correct unsigned magnitude
  assign o_absRs1 = w_rs1Neg ? (~i_rs1 + 1'b1) : i_rs1;
  assign o_absRs2 = w_rs2Neg ? (~i_rs2 + 1'b1) : i_rs2;

  // Remainder takes the dividend sign; product and quotient take the XOR
  assign o_negResult = w_isRem ? w_rs1Neg : (w_rs1Neg ^ w_rs2Neg);

  assign w_divZero  = w_isDiv & (i_rs2 == '0);
  // Only the signed ops (DIV, REM) have funct3 bit 0 clear
  assign w_overflow = w_isDiv & ~i_op[0] & (i_rs1 == MIN_VAL) & (i_rs2 == ONES_VAL);

`ifdef MULDIV_ZERO_SKIP_EN
  assign w_zeroSkip = w_isDiv ? ((i_rs1 == '0) & (i_rs2 != '0))
                              : ((i_rs1 == '0) | (i_rs2 == '0));
`else
  assign w_zeroSkip = 1'b0;
`endif

  assign o_special = w_divZero | w_overflow | w_zeroSkip;

  // Divide-by-zero wins over the zero-skip result (0/0 still yields all ones)
  assign o_specialResult = w_divZero  ? (i_op[1] ? i_rs1 : ONES_VAL) :
                           w_overflow ? (i_op[1] ? '0 : MIN_VAL) :
                           '0;

endmodule

// File: rtl/ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit sitting after the ID/EX register.
// A radix-2 shift-add multiplier and a restoring divider share one adder and
// one accumulator/low-word register pair. Divide corner cases finish in one
// cycle. Operands are latched at start so upstream need not hold them.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start_i           M-extension instruction present (sampled in IDLE only)
//   op_i              funct3 of the operation
//   rs1_data_i        dividend / multiplicand
//   rs2_data_i        divisor / multiplier
//   flush_i           abort any operation, no done_o
//   busy_o            iterating
//   done_o            result valid, one cycle
//   result_o          result, held until replaced by the next completion
//   stall_req_o       pipeline stall while accepting or iterating
//
// Optional feature macro: MULDIV_ZERO_SKIP_EN (handled in muldiv_operand_prep)
// -----------------------------------------------------------------------------
module ex_muldiv_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            stall_req_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  muldiv_state_t   r_state;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_op;
  logic            r_neg;

  logic [XLEN-1:0]   w_absRs1;
  logic [XLEN-1:0]   w_absRs2;
  logic              w_negResult;
  logic              w_special;
  logic [XLEN-1:0]   w_specialResult;
  logic              w_isDiv;
  logic [XLEN:0]     w_opA;
  logic [XLEN:0]     w_addend;
  logic [XLEN:0]     w_sum;
  logic [XLEN-1:0]   w_nextAcc;
  logic [XLEN-1:0]   w_nextLo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prodSigned;
  logic [XLEN-1:0]   w_mulResult;
  logic [XLEN-1:0]   w_divRaw;
  logic [XLEN-1:0]   w_divResult;
  logic [XLEN-1:0]   w_final;

  muldiv_operand_prep #(
    .XLEN (XLEN)
  ) u_prep (
    .i_op            (op_i),
    .i_rs1           (rs1_data_i),
    .i_rs2           (rs2_data_i),
    .o_absRs1        (w_absRs1),
    .o_absRs2        (w_absRs2),
    .o_negResult     (w_negResult),
    .o_special       (w_special),
    .o_specialResult (w_specialResult)
  );

  // Shared adder. Multiply: acc + (multiplier LSB ? multiplicand : 0).
  // Divide: {acc, next dividend bit} - divisor, with bit XLEN as the borrow.
  assign w_isDiv  = r_op[2];
  assign w_opA    = w_isDiv ? {r_acc, r_lo[XLEN-1]} : {1'b0, r_acc};
  assign w_addend = w_isDiv ? ~{1'b0, r_b} : (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_sum    = w_opA + w_addend + {{XLEN{1'b0}}, w_isDiv};

  // Multiply shifts the {acc, lo} pair right; divide shifts it left and
  // restores the partial remainder when the subtraction borrowed.
  assign w_nextAcc = w_isDiv ? (w_sum[XLEN] ? w_opA[XLEN-1:0] : w_sum[XLEN-1:0])
                             : w_sum[XLEN:1];
  assign w_nextLo  = w_isDiv ? {r_lo[XLEN-2:0], ~w_sum[XLEN]}
                             : {w_sum[0], r_lo[XLEN-1:1]};

  // Final result from the values produced by the last iteration
  assign w_prod       = {w_nextAcc, w_nextLo};
  assign w_prodSigned = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_mulResult  = (r_op == OP_MUL) ? w_prodSigned[XLEN-1:0]
                                         : w_prodSigned[2*XLEN-1:XLEN];
  assign w_divRaw     = r_op[1] ? w_nextAcc : w_nextLo;
  assign w_divResult  = r_neg ? (~w_divRaw + 1'b1) : w_divRaw;
  assign w_final      = w_isDiv ? w_divResult : w_mulResult;

  // Controller and datapath registers. Flush returns to IDLE without touching
  // the result; start is only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_count  <= '0;
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_op    <= op_i;
            r_neg   <= w_negResult;
            r_count <= '0;
            if (w_special) begin
              r_result <= w_specialResult;
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
            end else begin
              r_acc   <= '0;
              // Multiply shifts the multiplier through lo; divide shifts the
              // dividend through lo and keeps the divisor in b.
              r_lo    <= op_i[2] ? w_absRs1 : w_absRs2;
              r_b     <= op_i[2] ? w_absRs2 : w_absRs1;
              r_state <= ST_CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_nextAcc;
          r_lo  <= w_nextLo;
          if (r_count == LAST_ITER) begin
            r_count  <= '0;
            r_result <= w_final;
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign result_o    = r_result;
  // Dropped in DONE so the pipeline advances while the result is consumed
  assign stall_req_o = ((r_state == ST_IDLE) & start_i & ~flush_i) | (r_state == ST_CALC);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Self-checking bench for ex_muldiv_unit. Expected results come from plain
// 64-bit / integer arithmetic following the RV32M rules; expected latency
// follows the IDLE->DONE / IDLE->CALC rules, including MULDIV_ZERO_SKIP_EN.
// -----------------------------------------------------------------------------
module tb_ex_muldiv_unit;
  import riscv_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        stall_req_o;

  int vectors    = 0;
  int miscompares = 0;
  logic [31:0] heldResult;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  // Reference result straight from the RV32M definitions
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_MUL:    begin p = {32'b0, a} * {32'b0, b};                 return p[31:0];  end
      OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};     return p[63:32]; end
      OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b};           return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b};                 return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return ALL_ONES;
        if (a == MIN_INT && b == ALL_ONES) return MIN_INT;
        return 32'(sa / sb);
      end
      OP_DIVU: begin
        if (b == 0) return ALL_ONES;
        return a / b;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == ALL_ONES) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Reference latency (cycles from start to done)
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit quick;
    quick = (op >= OP_DIV && b == 0) ||
            ((op == OP_DIV || op == OP_REM) && a == MIN_INT && b == ALL_ONES);
`ifdef MULDIV_ZERO_SKIP_EN
    if (op < OP_DIV && (a == 0 || b == 0)) quick = 1'b1;
    if (op >= OP_DIV && a == 0 && b != 0) quick = 1'b1;
`endif
    return quick ? 1 : 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return MIN_INT;
      2:       return ALL_ONES;
      3:       return 32'($urandom_range(1, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Drives one start pulse and waits (bounded) for done_o
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat, output int stallCycles,
                               output logic stallAtDone);
    bit timedOut;
    res = '0; lat = 0; stallCycles = 0; stallAtDone = 1'b0; timedOut = 1'b1;
    @(posedge clk); #1;
    op_i = op; rs1_data_i = a; rs2_data_i = b; start_i = 1'b1;
    @(negedge clk);
    if (stall_req_o) stallCycles++;
    @(posedge clk); #1;
    start_i = 1'b0;
    op_i = 3'($urandom); rs1_data_i = $urandom; rs2_data_i = $urandom;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      if (done_o) begin
        lat = c; res = result_o; stallAtDone = stall_req_o; timedOut = 1'b0;
        break;
      end
      if (stall_req_o) stallCycles++;
      @(posedge clk); #1;
    end
    if (timedOut) begin
      vectors++; miscompares++;
      $display("[TB] FAIL done_timeout: op=%0d a=%h b=%h got no done_o, required within 200 cycles",
               op, a, b);
    end
  endtask

  // Runs one op and compares result and latency against the reference
  task automatic checkOutput(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b);
    logic [31:0] res;
    logic [31:0] expRes;
    int lat;
    int expLat;
    int st;
    logic sd;
    expRes = ref_result(op, a, b);
    expLat = ref_latency(op, a, b);
    applyStimulus(op, a, b, res, lat, st, sd);
    vectors++;
    if (res !== expRes) begin
      miscompares++;
      $display("[TB] FAIL %s_result: op=%0d a=%h b=%h got %h required %h", name, op, a, b, res, expRes);
    end
    vectors++;
    if (lat !== expLat) begin
      miscompares++;
      $display("[TB] FAIL %s_latency: op=%0d got %0d required %0d", name, op, lat, expLat);
    end
    heldResult = expRes;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy_o, done_o, stall_req_o, result_o} !== 35'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b stall=%b result=%h required all zero",
               busy_o, done_o, stall_req_o, result_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    heldResult = '0;
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int lat;
    int st;
    logic sd;
    applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, res, lat, st, sd);
    vectors++;
    if (res !== 32'hFFFF_FFEB) begin
      miscompares++;
      $display("[TB] FAIL mul_neg_result: got %h required %h", res, 32'hFFFF_FFEB);
    end
    vectors++;
    if (lat !== 33 || st !== 33 || sd !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mul_timing: got lat=%0d stallCycles=%0d stallAtDone=%b required 33 33 0",
               lat, st, sd);
    end
    @(posedge clk); @(negedge clk);
    vectors++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_one_cycle: got done=%b busy=%b required 0 0", done_o, busy_o);
    end
    checkOutput("mulh_min", OP_MULH, MIN_INT, MIN_INT);
    checkOutput("mulhu_ones", OP_MULHU, ALL_ONES, ALL_ONES);
    checkOutput("mulhsu", OP_MULHSU, ALL_ONES, 32'd2);
    checkOutput("mul_zero", OP_MUL, 32'd0, 32'd5);
  endtask

  task automatic test_div();
    checkOutput("div_by_zero", OP_DIV, 32'd7, 32'd0);
    checkOutput("remu_by_zero", OP_REMU, 32'd7, 32'd0);
    checkOutput("div_overflow", OP_DIV, MIN_INT, ALL_ONES);
    checkOutput("rem_overflow", OP_REM, MIN_INT, ALL_ONES);
    checkOutput("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    checkOutput("divu_big", OP_DIVU, ALL_ONES, 32'd2);
  endtask

  task automatic test_flush();
    logic [31:0] expRes;
    int doneCycle;
    @(posedge clk); #1;
    op_i = OP_DIVU; rs1_data_i = 32'h1234_5678; rs2_data_i = 32'h0000_0123; start_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    op_i = OP_DIV; rs1_data_i = 32'h8765_4321; rs2_data_i = 32'h0000_0035; start_i = 1'b1;
    expRes = ref_result(OP_DIV, 32'h8765_4321, 32'h0000_0035);
    @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== heldResult) begin
      miscompares++;
      $display("[TB] FAIL flush_abort: got busy=%b done=%b result=%h required 0 0 %h",
               busy_o, done_o, result_o, heldResult);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    doneCycle = 0;
    for (int c = 12; c < 120; c++) begin
      @(negedge clk);
      if (done_o) begin doneCycle = c; break; end
      @(posedge clk); #1;
    end
    vectors++;
    if (doneCycle !== 44 || result_o !== expRes) begin
      miscompares++;
      $display("[TB] FAIL flush_restart: got cycle=%0d result=%h required 44 %h",
               doneCycle, result_o, expRes);
    end
    heldResult = expRes;
  endtask

  task automatic test_reset_abort();
    bit sawDone;
    @(posedge clk); #1;
    op_i = OP_MUL; rs1_data_i = 32'h0000_1234; rs2_data_i = 32'h0000_5678; start_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_abort: got busy=%b done=%b result=%h required 0 0 0",
               busy_o, done_o, result_o);
    end
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) sawDone = 1'b1;
    end
    vectors++;
    if (sawDone !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_done: got done after reset required none");
    end
    heldResult = '0;
  endtask

  task automatic test_flush_start();
    bit sawActivity;
    @(posedge clk); #1;
    op_i = OP_MULHU; rs1_data_i = 32'h0000_0009; rs2_data_i = 32'h0000_0003;
    start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall_req_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_start_stall: got %b required 0", stall_req_o);
    end
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    sawActivity = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy_o || done_o) sawActivity = 1'b1;
    end
    vectors++;
    if (sawActivity !== 1'b0 || result_o !== heldResult) begin
      miscompares++;
      $display("[TB] FAIL flush_start_ignored: got activity=%b result=%h required 0 %h",
               sawActivity, result_o, heldResult);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, exp1, exp2;
    int doneCycle;
    a1 = $urandom | 32'd1; b1 = $urandom | 32'd1;
    a2 = $urandom | 32'd1; b2 = $urandom | 32'd1;
    exp1 = ref_result(OP_MULHU, a1, b1);
    exp2 = ref_result(OP_REM, a2, b2);
    @(posedge clk); #1;
    op_i = OP_MULHU; rs1_data_i = a1; rs2_data_i = b1; start_i = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    @(posedge clk); #1;
    op_i = OP_REM; rs1_data_i = a2; rs2_data_i = b2; start_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (done_o !== 1'b1 || result_o !== exp1 || stall_req_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got done=%b result=%h stall=%b required 1 %h 0",
               done_o, result_o, stall_req_o, exp1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (stall_req_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept_stall: got %b required 1", stall_req_o);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    doneCycle = 0;
    for (int c = 35; c < 150; c++) begin
      @(negedge clk);
      if (done_o) begin doneCycle = c; break; end
      @(posedge clk); #1;
    end
    vectors++;
    if (doneCycle !== 34 + ref_latency(OP_REM, a2, b2) || result_o !== exp2) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got cycle=%0d result=%h required %0d %h",
               doneCycle, result_o, 34 + ref_latency(OP_REM, a2, b2), exp2);
    end
    heldResult = exp2;
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      checkOutput("random", op, pick_operand(), pick_operand());
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_reset_abort();
    test_flush_start();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
